// File: rtl/dm_access_unit.sv
// Single-port data memory access unit: 3-cycle handshake (IDLE/ACCESS/DONE),
// byte/half/word loads and stores, ll/sc reservation, fault reporting.
module dm_access_unit #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  MemWr,
  input  logic [1:0]  DMcut_sel,
  input  logic        link,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [1:0]  cut;
    logic        link;
  } req_t;

  state_e          state_q, state_d;
  req_t            req_q;
  logic [31:0]     mem_q [DEPTH];
  logic            link_valid_q;
  logic [AW-1:0]   link_addr_q;
  logic            ack_q, err_q;
  logic [31:0]     rdata_q;

  logic [AW-1:0]   idx;
  logic [1:0]      bl;
  logic            is_ld, is_sw, is_sb, is_sh, is_sc, is_nop;
  logic            bad_op, oob, mis, fault, lk_hit, we;
  logic [3:0]      be;
  logic [31:0]     wword, rword, shifted, res;

  // Request is captured at accept so the requester's hold is not relied on later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req)
        req_q <= {addr, wdata, MemWr, DMcut_sel, link};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx    = req_q.addr[AW+1:2];
    bl     = req_q.addr[1:0];
    is_ld  = req_q.op == 3'b000;
    is_sw  = req_q.op == 3'b001;
    is_sb  = req_q.op == 3'b010;
    is_sh  = req_q.op == 3'b100;
    is_sc  = req_q.op == 3'b011;
    is_nop = req_q.op == 3'b101;
    bad_op = (req_q.op inside {3'b110, 3'b111}) || (is_ld && req_q.cut == 2'b11);
    oob    = |req_q.addr[31:AW+2];
    mis    = ((is_sw || is_sc || (is_ld && req_q.cut == 2'b00)) && bl != 2'b00) ||
             ((is_sh || (is_ld && req_q.cut == 2'b10)) && bl[0]);
    fault  = !is_nop && (bad_op || oob || mis);
    rword  = mem_q[idx];
    lk_hit = link_valid_q && link_addr_q == idx;

    // Narrow stores replicate their data across lanes; byte enables pick the lane.
    be    = 4'b0000;
    wword = req_q.wdata;
    if (is_sw || (is_sc && lk_hit)) begin
      be = 4'b1111;
    end else if (is_sb) begin
      be    = 4'b0001 << bl;
      wword = {4{req_q.wdata[7:0]}};
    end else if (is_sh) begin
      be    = bl[1] ? 4'b1100 : 4'b0011;
      wword = {2{req_q.wdata[15:0]}};
    end
    we = state_q == ACCESS && !fault && |be;

    shifted = rword >> {bl, 3'b000};
    res     = '0;
    if (!fault) begin
      if (is_ld) begin
        unique case (req_q.cut)
          2'b01:   res = {24'h0, shifted[7:0]};
          2'b10:   res = {16'h0, shifted[15:0]};
          default: res = rword;
        endcase
      end else if (is_sc) begin
        res = {31'h0, lk_hit};
      end
    end
  end

  // Array has no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      if (state_q == ACCESS) begin
        ack_q   <= 1'b1;
        err_q   <= fault;
        rdata_q <= res;
        if (!fault) begin
          if (is_ld && req_q.link) begin
            link_valid_q <= 1'b1;
            link_addr_q  <= idx;
          end else if (is_sc) begin
            link_valid_q <= 1'b0;
          end else if ((is_sw || is_sb || is_sh) && lk_hit) begin
            link_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = state_q != IDLE;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: byte-level memory/link model, per-cycle output
// compare against an expectation queue, directed literal cases plus random ops.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  MemWr = '0;
  logic [1:0]  DMcut_sel = '0;
  logic        link = 1'b0;
  logic        ack, err, busy;
  logic [31:0] rdata;

  dm_access_unit #(.AW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
    .MemWr(MemWr), .DMcut_sel(DMcut_sel), .link(link),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t        expq[$];
  int          cyc = 0;
  int          nchk = 0, nfail = 0;
  int          last_ack_cyc = 0;
  logic [31:0] mem_m [256];
  logic        lv_m = 1'b0;
  int unsigned la_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, got, exp);
    end
  endtask

  // Reference: sizes, offsets and byte lanes computed straight from the access rules.
  function automatic void model(input logic [2:0] op, input logic [1:0] cut, input logic lnk,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int unsigned w, off, sz;
    w  = (a >> 2) & 255;
    off = a & 3;
    rd = '0;
    er = 1'b0;
    case (op)
      3'b000:         sz = (cut == 0) ? 4 : (cut == 1) ? 1 : (cut == 2) ? 2 : 0;
      3'b001, 3'b011: sz = 4;
      3'b010:         sz = 1;
      3'b100:         sz = 2;
      3'b101:         return;
      default:        sz = 0;
    endcase
    if (sz == 0 || a > 1023 || (off % sz) != 0) begin
      er = 1'b1;
      return;
    end
    if (op == 3'b000) begin
      rd = mem_m[w] >> (8 * off);
      if (sz < 4) rd = rd & ((32'd1 << (8 * sz)) - 1);
      if (lnk) begin lv_m = 1'b1; la_m = w; end
    end else if (op == 3'b011) begin
      if (lv_m && la_m == w) begin mem_m[w] = wd; rd = 32'd1; end
      lv_m = 1'b0;
    end else begin
      for (int b = 0; b < int'(sz); b++) mem_m[w][8*(int'(off)+b) +: 8] = wd[8*b +: 8];
      if (lv_m && la_m == w) lv_m = 1'b0;
    end
  endfunction

  // Single compare process: every cycle, ack/busy and (on ack) rdata/err.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      expq.delete();
    end else begin
      logic exp_ack;
      exp_ack = expq.size() > 0 && expq[0].due == cyc;
      chk("ack", {31'h0, ack}, {31'h0, exp_ack});
      chk("busy", {31'h0, busy}, {31'h0, expq.size() > 0});
      if (exp_ack) begin
        chk("rdata", rdata, expq[0].rd);
        chk("err", {31'h0, err}, {31'h0, expq[0].er});
        void'(expq.pop_front());
      end
    end
  end

  // Called #1 after an edge with the DUT in (or entering) IDLE; returns #1 after
  // the DONE->IDLE edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] cut, input logic lnk,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold,
                       output logic [31:0] mrd, output logic mer,
                       output logic [31:0] drd, output logic der);
    exp_t e;
    bit   got;
    MemWr = op; DMcut_sel = cut; link = lnk; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    model(op, cut, lnk, a, wd, mrd, mer);
    e.due = cyc + 1; e.rd = mrd; e.er = mer;
    expq.push_back(e);
    got = 1'b0; drd = '0; der = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; drd = rdata; der = err; last_ack_cyc = cyc; end
    end
    if (!got) begin
      nchk++; nfail++;
      $display("FAIL ack_timeout: no ack within 6 cycles (op %b addr %h)", op, a);
      expq.delete();
    end
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic dt(input string n, input logic [2:0] op, input logic [1:0] cut,
                    input logic lnk, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] xrd, input logic xer);
    logic [31:0] mrd, drd;
    logic        mer, der;
    issue(op, cut, lnk, a, wd, 1'b0, mrd, mer, drd, der);
    chk({n, "_model"}, mrd, xrd);
    chk({n, "_dut"}, drd, xrd);
    chk({n, "_err"}, {31'h0, der}, {31'h0, xer});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] mrd, drd, a, wd;
    logic        mer, der, lnk, hold;
    logic [2:0]  op;
    logic [1:0]  cut;
    int          acks[3];

    foreach (mem_m[i]) mem_m[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int w = 0; w < 256; w++)
      issue(3'b001, 2'b00, 1'b0, w * 4, $urandom, 1'b0, mrd, mer, drd, der);

    dt("sw10",   3'b001, 2'b00, 0, 32'h10,  32'h11223344, 32'h0,        0);
    dt("lw10",   3'b000, 2'b00, 0, 32'h10,  32'h0,        32'h11223344, 0);
    dt("sb11",   3'b010, 2'b00, 0, 32'h11,  32'h000000AA, 32'h0,        0);
    dt("lb11",   3'b000, 2'b01, 0, 32'h11,  32'h0,        32'h000000AA, 0);
    dt("lw10b",  3'b000, 2'b00, 0, 32'h10,  32'h0,        32'h1122AA44, 0);
    dt("sh12",   3'b100, 2'b00, 0, 32'h12,  32'h0000BEEF, 32'h0,        0);
    dt("lh12",   3'b000, 2'b10, 0, 32'h12,  32'h0,        32'h0000BEEF, 0);
    dt("sw13",   3'b001, 2'b00, 0, 32'h13,  32'h0BADF00D, 32'h0,        1);
    dt("lw10c",  3'b000, 2'b00, 0, 32'h10,  32'h0,        32'hBEEFAA44, 0);
    dt("lw400",  3'b000, 2'b00, 0, 32'h400, 32'h0,        32'h0,        1);
    dt("op110",  3'b110, 2'b00, 0, 32'h10,  32'h0,        32'h0,        1);
    dt("lcut11", 3'b000, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1);
    dt("nop",    3'b101, 2'b00, 0, 32'h10,  32'h0,        32'h0,        0);
    dt("sw20",   3'b001, 2'b00, 0, 32'h20,  32'h0,        32'h0,        0);
    dt("ll20",   3'b000, 2'b00, 1, 32'h20,  32'h0,        32'h0,        0);
    dt("sc20",   3'b011, 2'b00, 0, 32'h20,  32'h5,        32'h1,        0);
    dt("lw20",   3'b000, 2'b00, 0, 32'h20,  32'h0,        32'h5,        0);
    dt("sc20b",  3'b011, 2'b00, 0, 32'h20,  32'h7,        32'h0,        0);
    dt("ll20b",  3'b000, 2'b00, 1, 32'h20,  32'h0,        32'h5,        0);
    dt("sb21",   3'b010, 2'b00, 0, 32'h21,  32'h99,       32'h0,        0);
    dt("sc20c",  3'b011, 2'b00, 0, 32'h20,  32'h8,        32'h0,        0);
    dt("lw20b",  3'b000, 2'b00, 0, 32'h20,  32'h0,        32'h00009905, 0);

    // Reset lands in ACCESS of a store to a linked word.
    dt("sw30",   3'b001, 2'b00, 0, 32'h30,  32'h12345678, 32'h0,        0);
    dt("ll30",   3'b000, 2'b00, 1, 32'h30,  32'h0,        32'h12345678, 0);
    MemWr = 3'b001; DMcut_sel = 2'b00; link = 1'b0; addr = 32'h30; wdata = 32'hFFFFFFFF;
    req = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1; req = 1'b0; lv_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    dt("sc30",   3'b011, 2'b00, 0, 32'h30,  32'hAAAAAAAA, 32'h0,        0);
    dt("lw30",   3'b000, 2'b00, 0, 32'h30,  32'h0,        32'h12345678, 0);

    // Three accesses with req held continuously.
    for (int k = 0; k < 3; k++) begin
      issue(3'b000, 2'b00, 1'b0, 32'h10 + 4 * k, 32'h0, k < 2, mrd, mer, drd, der);
      acks[k] = last_ack_cyc;
    end
    chk("b2b_gap1", acks[1] - acks[0], 32'd3);
    chk("b2b_gap2", acks[2] - acks[1], 32'd3);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      cut = 2'b00; lnk = 1'b0;
      case (r)
        0, 1, 2: begin op = 3'b000; cut = 2'($urandom_range(0, 3)); lnk = ($urandom % 3) == 0; end
        3: op = 3'b001;
        4: op = 3'b010;
        5: op = 3'b100;
        6: op = 3'b011;
        7: op = 3'b101;
        8: op = ($urandom % 2) ? 3'b110 : 3'b111;
        default: begin op = 3'b000; lnk = 1'b1; end
      endcase
      if ($urandom_range(0, 15) == 0 && op != 3'b101) a = $urandom;
      else if ($urandom % 2) a = $urandom_range(0, 47);
      else a = $urandom_range(0, 1023);
      if ($urandom % 10 < 7) a = a & ~32'h3;
      wd = $urandom;
      hold = ($urandom % 2) && n < 399;
      issue(op, cut, lnk, a, wd, hold, mrd, mer, drd, der);
      if (!hold) idle($urandom_range(0, 2));
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 SHALL have parameter AW, default 8, meaning log2 of word depth (256 x 32-bit words, byte addresses 0..1023).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  1  access request; requester holds all request inputs stable until ack.
REQ-005 SHALL have port: addr  input  32  byte address.
REQ-006 SHALL have port: wdata  input  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
REQ-007 SHALL have port: MemWr  input  3  op code: 000 load, 001 sw, 010 sb, 100 sh, 011 sc, 101 nop/stop, others reserved.
REQ-008 SHALL have port: DMcut_sel  input  2  load width: 00 word, 01 byte zero-extended, 10 half zero-extended, 11 reserved.
REQ-009 SHALL have port: link  input  1  with MemWr=000, marks the load as ll.
REQ-010 SHALL have port: ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: rdata  output  32  load result, or sc status; valid only while ack=1.
REQ-012 SHALL have port: err  output  1  set with ack when the access faulted.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; IDLE moves to ACCESS only when req=1.
REQ-015 SHALL sample the request in IDLE, perform the array read/write in ACCESS, and assert ack for exactly one cycle in DONE; accept-to-ack latency is 2 cycles.
REQ-016 SHALL ignore req in ACCESS and DONE; a req held high after ack starts a new access from IDLE on the following cycle, so back-to-back accesses take 3 cycles each.
REQ-017 SHALL use little-endian lane selection: byte lane addr[1:0], half lane addr[1].
REQ-018 SHALL fault (err=1, no write, rdata=0) when addr[31:AW+2] is non-zero.
REQ-019 SHALL fault on misalignment: word ops (MemWr 001/011, or load with DMcut_sel 00) with addr[1:0]!=0; half ops (MemWr 100, or load with DMcut_sel 10) with addr[0]=1.
REQ-020 SHALL fault on a reserved MemWr code, or on a load with DMcut_sel=11.
REQ-021 SHALL treat MemWr=101 as a no-op: no array access, err=0, rdata=0, normal 2-cycle ack.
REQ-022 SHALL have sb write only the addressed byte lane and sh write only the addressed half lane; the other lanes stay unchanged.
REQ-023 SHALL, on a non-faulting ll, set link_valid=1 and link_addr=addr[AW+1:2].
REQ-024 SHALL, on sc, write the word and return rdata=1 only if link_valid=1 and link_addr matches; otherwise it SHALL not write and SHALL return rdata=0.
REQ-025 SHALL clear link_valid on every sc, whether it succeeds or fails.
REQ-026 SHALL clear link_valid on any successful sw, sb or sh to the linked word.
REQ-027 SHALL never modify link state on a faulting access.
REQ-028 SHALL register rdata, err and ack as outputs, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, on reset assertion at any time including mid-access, force state=IDLE, ack=0, err=0, rdata=0, busy=0 and link_valid=0 immediately.
REQ-030 SHALL abandon any access interrupted by reset: no write occurs after reset asserts.
REQ-031 SHALL not clear array contents on reset.
REQ-032 SHALL resume accepting req on the first rising edge after reset deasserts.

Verification
REQ-033 SHALL cover store-then-load: sw 0x11223344 @0x10, then load word @0x10 -> rdata=0x11223344 two cycles after accept.
REQ-034 SHALL cover byte and half lanes: sb 0xAA @0x11, then load byte @0x11 -> 0x000000AA; load word @0x10 -> 0x1122AA44; sh 0xBEEF @0x12, then load half @0x12 -> 0x0000BEEF.
REQ-035 SHALL cover faults: sw @0x13 -> err=1 with memory unchanged; load @0x400 -> err=1, rdata=0; MemWr=110 -> err=1.
REQ-036 SHALL cover ll/sc: ll @0x20 then sc 5 @0x20 -> rdata=1 and the word is 5; a repeat sc -> rdata=0; ll @0x20, sb @0x21, then sc -> rdata=0 with no write.
REQ-037 SHALL cover reset mid-access: reset in ACCESS state of sw 0xFFFFFFFF @0x30 -> ack never pulses, word @0x30 keeps its old value, link_valid=0.
REQ-038 SHALL cover req held high: three queued accesses complete with ack pulses exactly 3 cycles apart and busy=0 only in IDLE cycles.
